rotation: RTL and testbench

//   CORDIC rotation-mode direction sequencer.
//   - Takes a target phase in integer degrees.
//   - Emits, one bit per clock, the micro-rotation direction sequence that drives the

---
 rtl/rotation.sv | 104 ++++++++++
 tb/tb_rotation.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rotation.sv
// ---------------------------------------------------------------------------
// rotation -- CORDIC rotation-mode direction sequencer
//
// Reduces a target phase in integer degrees to the range -179..+180. It then
// emits, one bit per clock, the sign sequence that drives the residual angle z
// to zero. The sequence is a +/-90 deg pre-rotation followed by ITER
// +/-atan(2^-k) micro-steps. The downstream rotator applies one
// micro-rotation per o_dir bit.
//
// Ports
//   clock    in   1   system clock, rising edge
//   reset    in   1   synchronous, active-low reset
//   i_angle  in   16  target phase, unsigned degrees (taken mod 360)
//   o_dir    out  1   registered direction: 1 = rotate positive (subtract step)
// ---------------------------------------------------------------------------
module rotation #(
  parameter int ITER = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] i_angle,
  output logic        o_dir
);

  localparam logic [3:0]  K_LAST = 4'(ITER);
  localparam logic [3:0]  K_IDLE = 4'(ITER + 1);
  // 360 deg in residual units (1 LSB = 1/128 deg)
  localparam logic [17:0] FULL_TURN = 18'd46080;

  // Step table in 1/128 deg: 90 deg, then atan(2^-(k-1)) rounded to nearest
  function automatic logic signed [17:0] step_tab(input logic [3:0] k);
    case (k)
      4'd0:    step_tab = 18'sd11520;
      4'd1:    step_tab = 18'sd5760;
      4'd2:    step_tab = 18'sd3400;
      4'd3:    step_tab = 18'sd1797;
      4'd4:    step_tab = 18'sd912;
      4'd5:    step_tab = 18'sd458;
      4'd6:    step_tab = 18'sd229;
      4'd7:    step_tab = 18'sd115;
      4'd8:    step_tab = 18'sd57;
      4'd9:    step_tab = 18'sd29;
      4'd10:   step_tab = 18'sd14;
      4'd11:   step_tab = 18'sd7;
      4'd12:   step_tab = 18'sd4;
      default: step_tab = 18'sd0;
    endcase
  endfunction

  logic [8:0]         ang_red;
  logic signed [17:0] z_load;
  logic               dir_step;
  logic signed [17:0] tab_k;

  logic [8:0]         last_q, last_d;
  logic signed [17:0] z_q, z_d;
  logic [3:0]         k_q, k_d;
  logic               dir_q, dir_d;

  assign ang_red = 9'(i_angle % 16'd360);

  // a*128, folded into -179..+180 by subtracting a full turn when a > 180.
  // The 18-bit wrap of the subtraction yields the two's-complement value.
  assign z_load = $signed({2'b00, ang_red, 7'b0} -
                          ((ang_red > 9'd180) ? FULL_TURN : 18'd0));

  // z == 0 counts as positive
  assign dir_step = ~z_q[17];
  assign tab_k    = step_tab(k_q);

  always_comb begin
    last_d = last_q;
    z_d    = z_q;
    k_d    = k_q;
    dir_d  = dir_q;
    if (ang_red != last_q) begin
      // A new angle restarts the sequence; o_dir holds for this edge
      last_d = ang_red;
      z_d    = z_load;
      k_d    = 4'd0;
    end else if (k_q <= K_LAST) begin
      dir_d = dir_step;
      z_d   = dir_step ? (z_q - tab_k) : (z_q + tab_k);
      k_d   = k_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q <= 9'd0;
      z_q    <= 18'sd0;
      k_q    <= K_IDLE;
      dir_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      z_q    <= z_d;
      k_q    <= k_d;
      dir_q  <= dir_d;
    end
  end

  assign o_dir = dir_q;

endmodule

// File: tb/tb_rotation.sv
module tb_rotation;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] i_angle = 16'd0;
  logic        o_dir;

  rotation #(.ITER(12)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_angle (i_angle),
    .o_dir   (o_dir)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit    exp;
    string name;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the whole direction sequence is computed on load and
  // then played out one bit per clock.
  int tab[13] = '{11520, 5760, 3400, 1797, 912, 458, 229, 115, 57, 29, 14, 7, 4};
  int m_last = 0;
  bit m_dir  = 1'b0;
  bit m_pend[$];

  bit seq30[13]  = '{1,0,0,1,0,1,1,0,1,0,0,1,1};
  bit seq330[13] = '{0,1,1,0,1,0,0,1,0,1,1,0,0};
  bit seq180[13] = '{1,1,1,1,1,0,1,0,0,1,1,1,1};

  function automatic void gen(int a);
    int s;
    int z;
    bit d;
    m_pend.delete();
    s = (a > 180) ? a - 360 : a;
    z = s * 128;
    for (int k = 0; k < 13; k++) begin
      d = (z >= 0);
      m_pend.push_back(d);
      z = d ? z - tab[k] : z + tab[k];
    end
  endfunction

  // Drive one clock's inputs and queue the o_dir value expected after that edge.
  // lit >= 0 forces a literal expectation; otherwise the model supplies it.
  task automatic cyc(input bit rstn, input int ang, input int lit, input string tag);
    int a;
    bit e;
    @(negedge clock);
    reset   = rstn;
    i_angle = 16'(ang);
    a = ang % 360;
    if (!rstn) begin
      m_last = 0;
      m_pend.delete();
      m_dir = 1'b0;
    end else if (a != m_last) begin
      m_last = a;
      gen(a);
    end else if (m_pend.size() > 0) begin
      m_dir = m_pend.pop_front();
    end
    e = (lit >= 0) ? bit'(lit) : m_dir;
    expq.push_back('{e, tag});
  endtask

  // Monitor: o_dir is valid every clock; compare whenever an expectation exists
  initial begin
    forever begin
      exp_t x;
      @(posedge clock);
      #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        n_cmp++;
        if (o_dir !== x.exp) begin
          n_bad++;
          $display("FAIL %s: o_dir=%0b expected=%0b at t=%0t", x.name, o_dir, x.exp, $time);
        end
      end
    end
  end

  initial begin
    int ang;
    int prev;
    int len;
    bit rstn;

    repeat (2) cyc(1'b0, 0, 0, "reset");

    // 30 deg held: load edge keeps o_dir, then 13 bits, then hold
    cyc(1'b1, 30, 0, "load30");
    for (int i = 0; i < 13; i++) cyc(1'b1, 30, int'(seq30[i]), "seq30");
    repeat (3) cyc(1'b1, 30, 1, "hold30");

    cyc(1'b1, 330, 1, "load330");
    for (int i = 0; i < 13; i++) cyc(1'b1, 330, int'(seq330[i]), "seq330");
    repeat (2) cyc(1'b1, 330, 0, "hold330");

    cyc(1'b1, 180, 0, "load180");
    for (int i = 0; i < 13; i++) cyc(1'b1, 180, int'(seq180[i]), "seq180");
    repeat (2) cyc(1'b1, 180, 1, "hold180");

    // 90 deg: z is exactly 0 after the pre-rotation and must count positive
    cyc(1'b1, 90, 1, "load90");
    cyc(1'b1, 90, 1, "bit0_90");
    cyc(1'b1, 90, 1, "bit1_90_zero");
    repeat (13) cyc(1'b1, 90, -1, "seq90");

    // Restart mid-sequence: 3 bits of 30, then 330
    cyc(1'b1, 30, -1, "load30b");
    cyc(1'b1, 30, 1, "r30_b0");
    cyc(1'b1, 30, 0, "r30_b1");
    cyc(1'b1, 30, 0, "r30_b2");
    cyc(1'b1, 330, 0, "restart_hold");
    for (int i = 0; i < 13; i++) cyc(1'b1, 330, int'(seq330[i]), "restart330");

    // Equivalent angle does not retrigger; reset aborts; angle 0 stays idle
    cyc(1'b1, 10, -1, "load10");
    repeat (4) cyc(1'b1, 10, -1, "seq10");
    repeat (4) cyc(1'b1, 370, -1, "equiv370");
    cyc(1'b0, 370, 0, "rst_mid");
    repeat (5) cyc(1'b1, 0, 0, "idle0");
    repeat (3) cyc(1'b1, 360, 0, "idle360");

    // Randomized bursts, including equivalent angles and occasional resets
    prev = 0;
    for (int b = 0; b < 40; b++) begin
      if ($urandom_range(0, 3) == 0)
        ang = (prev % 360) + 360 * int'($urandom_range(0, 180));
      else
        ang = int'($urandom_range(0, 65535));
      rstn = ($urandom_range(0, 9) != 0);
      len  = int'($urandom_range(1, 18));
      for (int j = 0; j < len; j++) cyc((j == 0) ? rstn : 1'b1, ang, -1, "rand");
      prev = ang;
    end

    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d expected=0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
